// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encodings, UART timing constants and width helper
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 9600;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - rotate-priority encoder picking the first request at or above ptr
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      index,
    output logic               valid
);

    int j;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        j      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                winner[j] = 1'b1;
                index     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_byte_tx among NUM_REQ byte producers
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 timeout_err,
    output logic                 busy,
    output logic                 Send_Go,
    output logic [7:0]           Data,
    input  logic                 Tx_Done
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = width_min1(TIMEOUT_CYC);
    localparam int GW = width_min1(GAP_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t             state, state_nx;
    logic [IW-1:0]      ptr, ptr_nx, owner, owner_nx;
    logic [TW-1:0]      tcnt, tcnt_nx;
    logic [GW-1:0]      gcnt, gcnt_nx;
    logic [NUM_REQ-1:0] grant_nx, done_nx;
    logic               terr_nx, go_nx, busy_nx, finish;
    logic [7:0]         data_nx;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .index  (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        tcnt_nx  = '0;
        gcnt_nx  = '0;
        grant_nx = '0;
        done_nx  = '0;
        terr_nx  = 1'b0;
        go_nx    = 1'b0;
        data_nx  = Data;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nx = pick_onehot;
                    go_nx    = 1'b1;
                    data_nx  = req_data[int'(pick_idx)*8 +: 8];
                    ptr_nx   = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IW'(1);
                    owner_nx = pick_idx;
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tcnt_nx = tcnt + TW'(1);
                // Send_Go is still high in the launch cycle, so a Tx_Done there belongs to nothing we sent
                if (Tx_Done && !Send_Go) begin
                    done_nx[owner] = 1'b1;
                    finish         = 1'b1;
                end else if (tcnt == T_LAST) begin
                    terr_nx = 1'b1;
                    finish  = 1'b1;
                end
                if (finish) begin
                    tcnt_nx  = '0;
                    state_nx = (GAP_CYC > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gcnt_nx = gcnt + GW'(1);
                if (gcnt == G_LAST) begin
                    gcnt_nx  = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            Send_Go     <= 1'b0;
            Data        <= 8'h00;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            owner       <= owner_nx;
            tcnt        <= tcnt_nx;
            gcnt        <= gcnt_nx;
            grant       <= grant_nx;
            done        <= done_nx;
            timeout_err <= terr_nx;
            busy        <= busy_nx;
            Send_Go     <= go_nx;
            Data        <= data_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic [3:0]  req_a, req_b, grant_a, grant_b, done_a, done_b;
    logic [31:0] data_a, data_b;
    logic        terr_a, terr_b, busy_a, busy_b, go_a, go_b;
    logic        txd_a = 1'b0, txd_b = 1'b0;
    logic [7:0]  dout_a, dout_b;
    logic        acc;

    int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
    int dly_a = 1, dly_b = 1, cnt_a = 0, cnt_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYC(0), .TIMEOUT_CYC(20)) dut_a (
        .CLK(clk), .Reset_n(Reset_n), .req(req_a), .req_data(data_a),
        .grant(grant_a), .done(done_a), .timeout_err(terr_a), .busy(busy_a),
        .Send_Go(go_a), .Data(dout_a), .Tx_Done(txd_a)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYC(5), .TIMEOUT_CYC(20)) dut_b (
        .CLK(clk), .Reset_n(Reset_n), .req(req_b), .req_data(data_b),
        .grant(grant_b), .done(done_b), .timeout_err(terr_b), .busy(busy_b),
        .Send_Go(go_b), .Data(dout_b), .Tx_Done(txd_b)
    );

    // Transmitter models: Tx_Done dly cycles after Send_Go; dly 0 pulses inside the Send_Go cycle
    always @(negedge clk) begin
        txd_a = 1'b0;
        if (!Reset_n) cnt_a = 0;
        else if (go_a) begin
            if (dly_a == 0) txd_a = 1'b1;
            else cnt_a = dly_a;
        end else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) txd_a = 1'b1;
        end
    end

    always @(negedge clk) begin
        txd_b = 1'b0;
        if (!Reset_n) cnt_b = 0;
        else if (go_b) begin
            if (dly_b == 0) txd_b = 1'b1;
            else cnt_b = dly_b;
        end else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) txd_b = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        req_a = '0; req_b = '0; data_a = '0; data_b = '0;
        repeat (2) step();
        chk("rst_grant", grant_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_terr", terr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_go", go_a, 0);
        chk("rst_data", dout_a, 8'h00);
        chk("rst_busy_b", busy_b, 0);

        // All four requesting continuously, one-cycle byte time
        Reset_n = 1'b1;
        data_a = 32'hA3A2A1A0;
        dly_a = 1;
        req_a = 4'b1111;
        step();
        for (int k = 0; k < 6; k++) begin
            chk("rr_go", go_a, 1);
            chk("rr_grant", grant_a, 32'(1) << (k % 4));
            chk("rr_data", dout_a, 8'hA0 + 8'(k % 4));
            if (k == 5) req_a = '0;
            step();
            chk("rr_one_grant", grant_a, 0);
            step();
            chk("rr_done", done_a, 32'(1) << (k % 4));
            chk("rr_idle", busy_a, 0);
            step();
        end
        chk("rr_quiet", go_a, 0);

        // Single request from requester 2, data changed after grant
        req_a = 4'b0100;
        data_a = 32'h0055_0000;
        dly_a = 3;
        step();
        chk("one_grant", grant_a, 4'b0100);
        chk("one_go", go_a, 1);
        chk("one_data", dout_a, 8'h55);
        chk("one_busy", busy_a, 1);
        req_a = '0;
        data_a = 32'hFFFF_FFFF;
        repeat (3) step();
        chk("one_no_done_yet", done_a, 0);
        chk("one_data_held", dout_a, 8'h55);
        step();
        chk("one_done", done_a, 4'b0100);
        chk("one_busy_low", busy_a, 0);
        chk("one_no_terr", terr_a, 0);
        step();
        chk("one_done_pulse", done_a, 0);

        // ptr=1, then simultaneous 1001: 3 before 0
        req_a = 4'b0001;
        data_a = 32'h3300_0011;
        dly_a = 1;
        step();
        chk("pre_grant0", grant_a, 4'b0001);
        req_a = 4'b1001;
        repeat (3) step();
        chk("wrap_grant3", grant_a, 4'b1000);
        chk("wrap_data3", dout_a, 8'h33);
        req_a = 4'b0001;
        repeat (3) step();
        chk("wrap_grant0", grant_a, 4'b0001);
        chk("wrap_data0", dout_a, 8'h11);
        req_a = '0;
        repeat (3) step();

        // Timeout: only Tx_Done arrives inside the Send_Go cycle and is ignored
        dly_a = 0;
        req_a = 4'b0010;
        data_a = 32'h0000_7700;
        step();
        chk("to_grant", grant_a, 4'b0010);
        chk("to_data", dout_a, 8'h77);
        req_a = 4'b0100;
        data_a = 32'h0088_0000;
        acc = 1'b0;
        for (int i = 1; i < 20; i++) begin
            step();
            acc = acc | (done_a != 0) | terr_a | (grant_a != 0);
        end
        chk("to_quiet", acc, 0);
        step();
        chk("to_terr", terr_a, 1);
        chk("to_no_done", done_a, 0);
        chk("to_idle", busy_a, 0);
        dly_a = 19;
        step();
        chk("to_next_grant", grant_a, 4'b0100);
        chk("to_next_data", dout_a, 8'h88);
        chk("to_terr_pulse", terr_a, 0);
        req_a = '0;
        acc = 1'b0;
        for (int i = 1; i < 20; i++) begin
            step();
            acc = acc | (done_a != 0) | terr_a | (grant_a != 0);
        end
        chk("tie_quiet", acc, 0);
        step();
        chk("tie_done", done_a, 4'b0100);
        chk("tie_no_terr", terr_a, 0);

        // Reset while waiting on a byte from requester 0
        req_a = 4'b0001;
        data_a = 32'h0000_00CC;
        dly_a = 5;
        step();
        chk("mid_grant", grant_a, 4'b0001);
        req_a = '0;
        repeat (2) step();
        Reset_n = 1'b0;
        step();
        chk("mid_grant0", grant_a, 0);
        chk("mid_done0", done_a, 0);
        chk("mid_terr0", terr_a, 0);
        chk("mid_busy0", busy_a, 0);
        chk("mid_go0", go_a, 0);
        chk("mid_data0", dout_a, 8'h00);
        Reset_n = 1'b1;
        req_a = 4'b0011;
        data_a = 32'h0000_2211;
        step();
        chk("post_grant0", grant_a, 4'b0001);
        chk("post_data0", dout_a, 8'h11);
        req_a = 4'b0010;
        repeat (6) step();
        chk("post_done0", done_a, 4'b0001);
        step();
        chk("post_grant1", grant_a, 4'b0010);
        chk("post_data1", dout_a, 8'h22);
        req_a = '0;
        repeat (6) step();
        chk("post_done1", done_a, 4'b0010);

        // Gap instance: byte time 4, GAP_CYC 5, request arriving during GAP
        dly_b = 4;
        req_b = 4'b0001;
        data_b = 32'h0000_B1B0;
        step();
        t0 = cyc;
        chk("gap_go0", go_b, 1);
        chk("gap_grant0", grant_b, 4'b0001);
        chk("gap_data0", dout_b, 8'hB0);
        req_b = '0;
        repeat (4) step();
        chk("gap_no_done", done_b, 0);
        step();
        chk("gap_done", done_b, 4'b0001);
        chk("gap_busy", busy_b, 1);
        step();
        req_b = 4'b0010;
        repeat (3) step();
        chk("gap_hold_grant", grant_b, 0);
        chk("gap_hold_busy", busy_b, 1);
        step();
        chk("gap_idle", busy_b, 0);
        chk("gap_idle_go", go_b, 0);
        step();
        chk("gap_go1", go_b, 1);
        chk("gap_grant1", grant_b, 4'b0010);
        chk("gap_data1", dout_b, 8'hB1);
        chk("gap_distance", cyc - t0, 11);
        req_b = '0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
